arb2_stream_sel: RTL and testbench

- Two-input stream arbiter that sits directly upstream of the 2:1 mux.
- Chooses one of two valid/ready source channels with round-robin priority.
- Holds the choice for a whole packet, which ends on a beat with `last`.
- Drives the mux `select` line and registers the chosen beat into a single-entry output stage, which feeds the downstream consumer.

---
 rtl/arb2_stream_sel.sv | 132 +++++++++++++
 tb/tb_arb2_stream_sel.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/arb2_stream_sel.sv
// Two-input round-robin stream arbiter that holds its grant for a whole packet
// and registers the chosen beat into a single-entry output stage.
module arb2_stream_sel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg, prio_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_last_reg, out_last_next;

    logic [1:0]       ch_valid;
    logic [1:0]       ch_last;
    logic [WIDTH-1:0] ch_data [2];
    logic [1:0]       ch_ready;

    logic             grant;
    logic             allow;
    logic             space;
    logic             accept;

    assign ch_valid   = {in1_valid, in0_valid};
    assign ch_last    = {in1_last, in0_last};
    assign ch_data[0] = in0_data;
    assign ch_data[1] = in1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prio_reg      <= prio_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
        end
    end

    always_comb begin
        grant          = prio_reg;
        allow          = 1'b0;
        state_next     = state_reg;
        prio_next      = prio_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;

        // In IDLE a lone requester wins outright; ties and silence fall back to prio.
        case (state_reg)
            IDLE: begin
                if (ch_valid == 2'b01)
                    grant = 1'b0;
                else if (ch_valid == 2'b10)
                    grant = 1'b1;
                else
                    grant = prio_reg;
                allow = ch_valid[grant];
            end
            LOCK0: begin
                grant = 1'b0;
                allow = 1'b1;
            end
            LOCK1: begin
                grant = 1'b1;
                allow = 1'b1;
            end
            default: begin
                grant = prio_reg;
                allow = 1'b0;
            end
        endcase

        space  = ~out_valid_reg | out_ready;
        accept = ~rst & space & allow & ch_valid[grant];

        if (accept) begin
            out_valid_next = 1'b1;
            out_data_next  = ch_data[grant];
            out_last_next  = ch_last[grant];
            if (ch_last[grant]) begin
                state_next = IDLE;
                prio_next  = ~grant;
            end else begin
                state_next = grant ? LOCK1 : LOCK0;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // Only the granted channel can ever see ready; a lock holds off the other one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ch_ready[gi] = ~rst & space & allow & (grant == 1'(gi));
        end
    endgenerate

    assign in0_ready = ch_ready[0];
    assign in1_ready = ch_ready[1];
    assign select    = grant & ~rst;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_arb2_stream_sel.sv
// Directed, table-driven bench for arb2_stream_sel: inputs are driven after the
// falling edge and all outputs are compared 1 ns later, before the next rising edge.
module tb_arb2_stream_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in0_last, in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid, in1_last, in1_ready;
    logic [7:0] in1_data;
    logic       select;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arb2_stream_sel #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .select    (select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Expected out_* are the register contents before the rising edge that follows.
    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       ordy;
        logic       e_r0;
        logic       e_r1;
        logic       e_sel;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic       co;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic rst_i, input logic v0, input logic [7:0] d0, input logic l0,
        input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
        input logic r0, input logic r1, input logic sel,
        input logic ov, input logic [7:0] od, input logic ol, input logic co);
        vec_t v;
        v.rst = rst_i; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
        v.e_r0 = r0; v.e_r1 = r1; v.e_sel = sel;
        v.e_ov = ov; v.e_od = od; v.e_ol = ol; v.co = co;
        return v;
    endfunction

    task automatic chk(input string nm, input string tag, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        in0_valid = v.v0; in0_data = v.d0; in0_last = v.l0;
        in1_valid = v.v1; in1_data = v.d1; in1_last = v.l1;
        out_ready = v.ordy;
        #1;
        chk("in0_ready", tag, {7'd0, in0_ready}, {7'd0, v.e_r0});
        chk("in1_ready", tag, {7'd0, in1_ready}, {7'd0, v.e_r1});
        chk("select",    tag, {7'd0, select},    {7'd0, v.e_sel});
        if (v.co) begin
            chk("out_valid", tag, {7'd0, out_valid}, {7'd0, v.e_ov});
            chk("out_data",  tag, out_data,          v.e_od);
            chk("out_last",  tag, {7'd0, out_last},  {7'd0, v.e_ol});
        end
        $display("%s rst=%0b v0=%0b d0=%h v1=%0b d1=%h ordy=%0b | r0=%0b r1=%0b sel=%0b ov=%0b od=%h ol=%0b",
                 tag, v.rst, v.v0, v.d0, v.v1, v.d1, v.ordy,
                 in0_ready, in1_ready, select, out_valid, out_data, out_last);
    endtask

    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
        out_ready = 1'b0;

        //              rst v0 d0     l0 v1 d1     l1 ordy r0 r1 sel ov od     ol co
        // reset with both valids high
        vecs[0]  = mk(1, 1, 8'h10, 1, 1, 8'h20, 1, 1,   0, 0, 0,  0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 1, 8'h10, 1, 1, 8'h20, 1, 1,   0, 0, 0,  0, 8'h00, 0, 1);
        // round-robin single-beat packets
        vecs[2]  = mk(0, 1, 8'h10, 1, 1, 8'h20, 1, 1,   1, 0, 0,  0, 8'h00, 0, 1);
        vecs[3]  = mk(0, 1, 8'h11, 1, 1, 8'h20, 1, 1,   0, 1, 1,  1, 8'h10, 1, 1);
        vecs[4]  = mk(0, 1, 8'h11, 1, 1, 8'h21, 1, 1,   1, 0, 0,  1, 8'h20, 1, 1);
        vecs[5]  = mk(0, 1, 8'h12, 1, 1, 8'h21, 1, 1,   0, 1, 1,  1, 8'h11, 1, 1);
        // ch1 three-beat packet locks out ch0
        vecs[6]  = mk(0, 0, 8'h05, 1, 1, 8'hA1, 0, 1,   0, 1, 1,  1, 8'h21, 1, 1);
        vecs[7]  = mk(0, 1, 8'h05, 1, 1, 8'hA2, 0, 1,   0, 1, 1,  1, 8'hA1, 0, 1);
        vecs[8]  = mk(0, 1, 8'h05, 1, 1, 8'hA3, 1, 1,   0, 1, 1,  1, 8'hA2, 0, 1);
        vecs[9]  = mk(0, 1, 8'h05, 1, 0, 8'h00, 0, 1,   1, 0, 0,  1, 8'hA3, 1, 1);
        // backpressure holding 0x33 for 4 cycles, then drain+accept together
        vecs[10] = mk(0, 1, 8'h33, 1, 0, 8'h00, 0, 1,   1, 0, 0,  1, 8'h05, 1, 1);
        vecs[11] = mk(0, 1, 8'h34, 1, 1, 8'h44, 1, 0,   0, 0, 1,  1, 8'h33, 1, 1);
        vecs[12] = mk(0, 1, 8'h34, 1, 1, 8'h44, 1, 0,   0, 0, 1,  1, 8'h33, 1, 1);
        vecs[13] = mk(0, 1, 8'h34, 1, 1, 8'h44, 1, 0,   0, 0, 1,  1, 8'h33, 1, 1);
        vecs[14] = mk(0, 1, 8'h34, 1, 1, 8'h44, 1, 0,   0, 0, 1,  1, 8'h33, 1, 1);
        vecs[15] = mk(0, 1, 8'h34, 1, 1, 8'h44, 1, 1,   0, 1, 1,  1, 8'h33, 1, 1);
        vecs[16] = mk(0, 1, 8'h34, 1, 0, 8'h00, 0, 1,   1, 0, 0,  1, 8'h44, 1, 1);
        // idle with nothing valid: drain, no prio change
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 1,  1, 8'h34, 1, 1);
        vecs[18] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 1,  0, 8'h34, 1, 1);
        vecs[19] = mk(0, 1, 8'h50, 1, 1, 8'h60, 1, 0,   0, 1, 1,  0, 8'h34, 1, 1);

        for (int i = 0; i < 20; i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // mid-packet gap on ch0: lock holds select=0 and in1_ready=0 through bubbles
        apply("gap0", mk(0, 1, 8'h01, 0, 1, 8'h70, 1, 1,   1, 0, 0,  1, 8'h60, 1, 1));
        apply("gap1", mk(0, 0, 8'h00, 0, 1, 8'h70, 1, 1,   1, 0, 0,  1, 8'h01, 0, 1));
        apply("gap2", mk(0, 0, 8'h00, 0, 1, 8'h70, 1, 1,   1, 0, 0,  0, 8'h01, 0, 1));
        apply("gap3", mk(0, 0, 8'h00, 0, 1, 8'h70, 1, 1,   1, 0, 0,  0, 8'h01, 0, 1));
        apply("gap4", mk(0, 1, 8'h02, 1, 1, 8'h70, 1, 1,   1, 0, 0,  0, 8'h01, 0, 1));
        apply("gap5", mk(0, 1, 8'h03, 1, 1, 8'h70, 1, 1,   0, 1, 1,  1, 8'h02, 1, 1));
        apply("gap6", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 0,  1, 8'h70, 1, 1));

        // reset in the middle of a ch1 packet: next tie goes to ch0
        apply("rmp0", mk(0, 0, 8'h00, 0, 1, 8'hB1, 0, 1,   0, 1, 1,  0, 8'h70, 1, 1));
        apply("rmp1", mk(1, 1, 8'hC1, 1, 1, 8'hB2, 0, 1,   0, 0, 0,  1, 8'hB1, 0, 1));
        apply("rmp2", mk(0, 1, 8'hC1, 1, 1, 8'hB2, 0, 1,   1, 0, 0,  0, 8'h00, 0, 1));
        apply("rmp3", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 1,  1, 8'hC1, 1, 1));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
